// File: rtl/add_sub_serial_wide.sv
// add_sub_serial_wide
//   Multi-cycle wide adder/subtractor. A W = DATA_SIZE*NUM_CHUNKS bit operation
//   is carried out on one DATA_SIZE-bit adder, one chunk per clock, LSB chunk
//   first. Each chunk computes a + (b ^ {ctrl}) + carry. The carry is kept in a
//   register between chunks. Starting the carry at ctrl turns the chunk adder
//   into a two's-complement subtractor.
//
// Handshake: start_in is a request, sampled only while the block is idle
//   (busy_out=0). On the edge where it is accepted, a_in/b_in/control_in are
//   captured and busy_out rises. done_out pulses high for exactly one cycle,
//   NUM_CHUNKS edges after acceptance. From that pulse onward, result_out and
//   the flags hold their values until the next completion. start_in seen while
//   busy is dropped, not queued.
//
// Ports
//   clk_in        in   rising-edge clock
//   rst_n_in      in   asynchronous active-low reset
//   start_in      in   operation request (sampled in IDLE only)
//   control_in    in   0 = a+b, 1 = a-b (captured with start)
//   a_in, b_in    in   W-bit operands (captured with start)
//   busy_out      out  high while not IDLE
//   done_out      out  one-cycle completion pulse
//   result_out    out  W-bit result, held until the next completion
//   carry_out     out  carry out of the MSB chunk (sub: 1 = no borrow)
//   overflow_out  out  signed overflow of the W-bit operation
//   zero_out      out  result_out == 0
//   state_dbg     out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module add_sub_serial_wide #(
  parameter int DATA_SIZE  = 4,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic                            control_in,
  input  logic [DATA_SIZE*NUM_CHUNKS-1:0] a_in,
  input  logic [DATA_SIZE*NUM_CHUNKS-1:0] b_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [DATA_SIZE*NUM_CHUNKS-1:0] result_out,
  output logic                            carry_out,
  output logic                            overflow_out,
  output logic                            zero_out,
  output logic [1:0]                      state_dbg
);

  localparam int W     = DATA_SIZE * NUM_CHUNKS;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]         a_q, b_q, acc_q, acc_next;
  logic                 ctrl_q, carry_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_SIZE-1:0] a_chunk, b_chunk, b_eff;
  logic [DATA_SIZE:0]   sum;
  logic                 msb_cin;
  logic                 last_chunk;

  assign last_chunk = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_out  = (state_q != S_IDLE);
    done_out  = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Chunk adder: select the current slice and write the sum back into a copy of
  // the accumulator. The final result can then include the last slice on the
  // same edge that produces it.
  always_comb begin
    a_chunk  = '0;
    b_chunk  = '0;
    acc_next = acc_q;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_q == k[IDX_W-1:0]) begin
        a_chunk = a_q[k*DATA_SIZE +: DATA_SIZE];
        b_chunk = b_q[k*DATA_SIZE +: DATA_SIZE];
      end
    end
    b_eff = b_chunk ^ {DATA_SIZE{ctrl_q}};
    sum   = {1'b0, a_chunk} + {1'b0, b_eff} + {{DATA_SIZE{1'b0}}, carry_q};
    // The carry into the MSB is recovered from the MSB sum bit and its two inputs.
    msb_cin = sum[DATA_SIZE-1] ^ a_chunk[DATA_SIZE-1] ^ b_eff[DATA_SIZE-1];
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_q == k[IDX_W-1:0]) acc_next[k*DATA_SIZE +: DATA_SIZE] = sum[DATA_SIZE-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= 1'b0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      acc_q        <= '0;
      result_out   <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            ctrl_q  <= control_in;
            carry_q <= control_in;
            idx_q   <= '0;
            acc_q   <= '0;
          end
        end
        S_RUN: begin
          acc_q   <= acc_next;
          carry_q <= sum[DATA_SIZE];
          if (!last_chunk) begin
            idx_q <= idx_q + 1'b1;
          end else begin
            result_out   <= acc_next;
            carry_out    <= sum[DATA_SIZE];
            overflow_out <= msb_cin ^ sum[DATA_SIZE];
            zero_out     <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
